// File: rtl/ppi_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a byte FIFO; registers DATA/STATUS/DIV at BASE_ADDR..+2.
// Optional parity bit is compiled in when UART_PARITY_EN is defined.
module ppi_uart_tx #(
  parameter logic [8:0]  BASE_ADDR  = 9'h010,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [8:0]  AddressOutIO,
  input  logic [31:0] DataOutputTowardIO,
  input  logic        WritePPI,
  output logic [31:0] DataOutPPI,
  output logic        SelPPI,
  output logic        TxD,
  output logic        TxBusy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [15:0]   baud_cnt_q;
  logic [15:0]   frame_div_q;
  logic          txd_q;
  logic [15:0]   div_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
`ifdef UART_PARITY_EN
  logic          par_en_q, par_odd_q;
  logic          frame_par_en_q, par_bit_q;
`endif

  logic [8:0]  offset;
  logic        wr_data, wr_stat, wr_div;
  logic        empty, full, baud_end, pop, push;
  logic [7:0]  head;
  logic [4:0]  cnt_ext;
  logic [31:0] rd_data;
  logic        unused_dat;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the 0..2 window.
  assign offset   = AddressOutIO - BASE_ADDR;
  assign SelPPI   = offset < 9'd3;
  assign wr_data  = WritePPI && (offset == 9'd0);
  assign wr_stat  = WritePPI && (offset == 9'd1);
  assign wr_div   = WritePPI && (offset == 9'd2);

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign baud_end = (baud_cnt_q == frame_div_q - 16'd1);
  assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
  assign push     = wr_data && (!full || pop);

  assign TxD      = txd_q;
  assign TxBusy   = (state_q != S_IDLE) || !empty;

`ifdef UART_PARITY_EN
  assign unused_dat = ^DataOutputTowardIO[31:18];
`else
  assign unused_dat = ^DataOutputTowardIO[31:16];
`endif

  always_comb begin
    cnt_ext = '0;
    cnt_ext[CW-1:0] = count_q;
    rd_data = '0;
    case (offset)
      9'd1: rd_data = {23'd0, cnt_ext, ovf_q, (state_q != S_IDLE), full, empty};
      9'd2: begin
        rd_data[15:0] = div_q;
`ifdef UART_PARITY_EN
        rd_data[16] = par_en_q;
        rd_data[17] = par_odd_q;
`endif
      end
      default: rd_data = '0;
    endcase
  end

  assign DataOutPPI = SelPPI ? rd_data : 32'd0;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= DataOutputTowardIO[7:0];
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
`ifdef UART_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_stat)
        ovf_q <= 1'b0;
      else if (wr_data && full && !pop)
        ovf_q <= 1'b1;
      if (wr_div) begin
        div_q <= (DataOutputTowardIO[15:0] < 16'd2) ? 16'd2 : DataOutputTowardIO[15:0];
`ifdef UART_PARITY_EN
        par_en_q  <= DataOutputTowardIO[16];
        par_odd_q <= DataOutputTowardIO[17];
`endif
      end
    end
  end

  // Popping a byte always starts a frame, whether from IDLE or straight out of STOP.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      txd_q          <= 1'b1;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      baud_cnt_q     <= '0;
      frame_div_q    <= DIV_RESET;
`ifdef UART_PARITY_EN
      frame_par_en_q <= 1'b0;
      par_bit_q      <= 1'b0;
`endif
    end else if (pop) begin
      state_q        <= S_START;
      txd_q          <= 1'b0;
      shift_q        <= head;
      bit_cnt_q      <= '0;
      baud_cnt_q     <= '0;
      frame_div_q    <= div_q;
`ifdef UART_PARITY_EN
      frame_par_en_q <= par_en_q;
      par_bit_q      <= (^head) ^ par_odd_q;
`endif
    end else begin
      case (state_q)
        S_IDLE: txd_q <= 1'b1;
        S_START: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            state_q    <= S_DATA;
            txd_q      <= shift_q[0];
            shift_q    <= shift_q >> 1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
              if (frame_par_en_q) begin
                state_q <= S_PARITY;
                txd_q   <= par_bit_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            state_q    <= S_STOP;
            txd_q      <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            state_q    <= S_IDLE;
            txd_q      <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_uart_tx.sv
// Directed bench for ppi_uart_tx: register map, frame timing, FIFO overflow, divisor change, reset abort.
module tb_ppi_uart_tx;

  localparam logic [8:0] BASE = 9'h010;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [8:0]  AddressOutIO;
  logic [31:0] DataOutputTowardIO;
  logic        WritePPI;
  logic [31:0] DataOutPPI;
  logic        SelPPI, TxD, TxBusy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ppi_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .CLK(CLK), .Reset(Reset), .AddressOutIO(AddressOutIO),
    .DataOutputTowardIO(DataOutputTowardIO), .WritePPI(WritePPI),
    .DataOutPPI(DataOutPPI), .SelPPI(SelPPI), .TxD(TxD), .TxBusy(TxBusy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // c = index of the edge that performed the write.
  task automatic wr_reg(input logic [1:0] off, input logic [31:0] d, output int c);
    @(negedge CLK);
    AddressOutIO = BASE + 9'(off);
    DataOutputTowardIO = d;
    WritePPI = 1'b1;
    @(posedge CLK);
    #1;
    WritePPI = 1'b0;
    c = cyc;
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [31:0] d);
    AddressOutIO = BASE + 9'(off);
    #1;
    d = DataOutPPI;
  endtask

  // Sample line and busy in the interval following edges t0 .. t0+n-1.
  task automatic capture(input int t0, input int n, output logic [199:0] v, output logic [199:0] b);
    v = '0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      while (cyc < t0 + i) @(negedge CLK);
      v[i] = TxD;
      b[i] = TxBusy;
    end
  endtask

  function automatic logic [199:0] frame_exp(input logic [7:0] by, input int div);
    logic [9:0] seq;
    logic [199:0] e;
    seq = {1'b1, by, 1'b0};
    e = '0;
    for (int i = 0; i < 10 * div; i++) e[i] = seq[i / div];
    return e;
  endfunction

  function automatic logic [199:0] ones(input int n);
    logic [199:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i] = 1'b1;
    return e;
  endfunction

  task automatic test_reset;
    logic [31:0] r;
    Reset = 1'b0;
    WritePPI = 1'b0;
    DataOutputTowardIO = '0;
    AddressOutIO = BASE + 9'd1;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", TxD); end
    checks++; if (TxBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", TxBusy); end
    rd_reg(2'd1, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=00000001", r); end
    rd_reg(2'd2, r);
    checks++; if (r !== 32'd434) begin failures++; $display("FAIL reset_div got=%0d exp=434", r); end
    rd_reg(2'd0, r);
    checks++; if (r !== 32'h0 || SelPPI !== 1'b1) begin failures++; $display("FAIL data_read got=%h sel=%b exp=0 sel=1", r, SelPPI); end
    AddressOutIO = BASE + 9'd3;
    #1;
    checks++; if (SelPPI !== 1'b0 || DataOutPPI !== 32'h0) begin failures++; $display("FAIL sel_above got sel=%b dat=%h exp 0/0", SelPPI, DataOutPPI); end
    AddressOutIO = BASE - 9'd1;
    #1;
    checks++; if (SelPPI !== 1'b0 || DataOutPPI !== 32'h0) begin failures++; $display("FAIL sel_below got sel=%b dat=%h exp 0/0", SelPPI, DataOutPPI); end
  endtask

  task automatic test_frame;
    int c, s;
    logic [199:0] v, b;
    wr_reg(2'd2, 32'd4, c);
    wr_reg(2'd0, 32'h0000_00A5, c);
    s = c + 1;
    capture(s, 40, v, b);
    checks++; if (v !== frame_exp(8'hA5, 4)) begin failures++; $display("FAIL frame_a5 got=%h exp=%h", v[39:0], frame_exp(8'hA5, 4) >> 0); end
    checks++; if (b !== ones(40)) begin failures++; $display("FAIL frame_busy got=%h exp=%h", b[39:0], ones(40)); end
    capture(s + 40, 1, v, b);
    checks++; if (b[0] !== 1'b0 || v[0] !== 1'b1) begin failures++; $display("FAIL frame_end got busy=%b txd=%b exp 0/1", b[0], v[0]); end
  endtask

  task automatic test_overflow;
    int c, s;
    logic [31:0] r;
    logic [199:0] v, b;
    wr_reg(2'd2, 32'd2, c);
    wr_reg(2'd0, 32'h30, c);
    s = c + 1;
    for (int k = 1; k <= 9; k++) wr_reg(2'd0, 32'(8'h30 + k), c);
    rd_reg(2'd1, r);
    checks++; if (r !== 32'h0000_008E) begin failures++; $display("FAIL ovf_status got=%h exp=0000008e", r); end
    for (int k = 1; k <= 8; k++) begin
      capture(s + 20 * k, 20, v, b);
      checks++;
      if (v !== frame_exp(8'(8'h30 + k), 2)) begin
        failures++;
        $display("FAIL b2b_frame%0d got=%h exp=%h", k, v[19:0], frame_exp(8'(8'h30 + k), 2) >> 0);
      end
    end
    capture(s + 179, 2, v, b);
    checks++; if (b[1:0] !== 2'b01) begin failures++; $display("FAIL b2b_busy_end got=%b exp=01", b[1:0]); end
    capture(s + 180, 30, v, b);
    checks++; if (v !== ones(30)) begin failures++; $display("FAIL dropped_byte_sent got=%h exp=%h", v[29:0], ones(30)); end
    rd_reg(2'd1, r);
    checks++; if (r !== 32'h9) begin failures++; $display("FAIL ovf_sticky got=%h exp=00000009", r); end
    wr_reg(2'd1, 32'hFFFF_FFFF, c);
    rd_reg(2'd1, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL ovf_clear got=%h exp=00000001", r); end
  endtask

  task automatic test_div_change;
    int c, s;
    logic [31:0] r;
    logic [199:0] v, b;
    wr_reg(2'd2, 32'd1, c);
    rd_reg(2'd2, r);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL div_min got=%0d exp=2", r); end
    wr_reg(2'd2, 32'd0, c);
    rd_reg(2'd2, r);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL div_zero got=%0d exp=2", r); end
    wr_reg(2'd0, 32'h5A, c);
    s = c + 1;
    wr_reg(2'd0, 32'hC3, c);
    wr_reg(2'd2, 32'd8, c);
    capture(s + 2, 18, v, b);
    checks++; if (v !== (frame_exp(8'h5A, 2) >> 2)) begin failures++; $display("FAIL div_old_frame got=%h exp=%h", v[17:0], frame_exp(8'h5A, 2) >> 2); end
    capture(s + 20, 80, v, b);
    checks++; if (v !== frame_exp(8'hC3, 8)) begin failures++; $display("FAIL div_new_frame got=%h exp=%h", v[79:0], frame_exp(8'hC3, 8) >> 0); end
    capture(s + 100, 1, v, b);
    checks++; if (b[0] !== 1'b0) begin failures++; $display("FAIL div_busy_end got=%b exp=0", b[0]); end
  endtask

  task automatic test_reset_mid;
    int c, s;
    logic [31:0] r;
    logic [199:0] v, b;
    wr_reg(2'd2, 32'd4, c);
    wr_reg(2'd0, 32'h00, c);
    s = c + 1;
    for (int k = 0; k < 3; k++) wr_reg(2'd0, 32'h00, c);
    while (cyc < s + 12) @(negedge CLK);
    checks++; if (TxD !== 1'b0) begin failures++; $display("FAIL pre_reset_txd got=%b exp=0", TxD); end
    Reset = 1'b0;
    #1;
    checks++; if (TxD !== 1'b1 || TxBusy !== 1'b0) begin failures++; $display("FAIL reset_abort got txd=%b busy=%b exp 1/0", TxD, TxBusy); end
    rd_reg(2'd1, r);
    checks++; if (r !== 32'h1 || SelPPI !== 1'b1) begin failures++; $display("FAIL reset_rd got=%h sel=%b exp=00000001 sel=1", r, SelPPI); end
    @(negedge CLK);
    Reset = 1'b1;
    rd_reg(2'd2, r);
    checks++; if (r !== 32'd434) begin failures++; $display("FAIL reset_div2 got=%0d exp=434", r); end
    capture(cyc, 60, v, b);
    checks++; if (v !== ones(60) || b !== '0) begin failures++; $display("FAIL reset_quiet got txd=%h busy=%h", v[59:0], b[59:0]); end
  endtask

  task automatic test_parity;
    int c, s;
    logic [31:0] r;
    logic [199:0] v, b;
`ifdef UART_PARITY_EN
    logic [10:0] seq;
    logic [199:0] e;
    wr_reg(2'd2, 32'h0003_0004, c);
    rd_reg(2'd2, r);
    checks++; if (r !== 32'h0003_0004) begin failures++; $display("FAIL par_div_rd got=%h exp=00030004", r); end
    wr_reg(2'd0, 32'h03, c);
    s = c + 1;
    seq = 11'b110_0000_0110;
    e = '0;
    for (int i = 0; i < 44; i++) e[i] = seq[i / 4];
    capture(s, 45, v, b);
    checks++; if (v[43:0] !== e[43:0]) begin failures++; $display("FAIL par_frame got=%h exp=%h", v[43:0], e[43:0]); end
    checks++; if (b[44:43] !== 2'b01) begin failures++; $display("FAIL par_busy_end got=%b exp=01", b[44:43]); end
    wr_reg(2'd2, 32'h0000_0004, c);
    wr_reg(2'd0, 32'h03, c);
    s = c + 1;
    capture(s, 41, v, b);
    checks++; if (v[39:0] !== frame_exp(8'h03, 4) >> 0 || b[40] !== 1'b0) begin failures++; $display("FAIL nopar_frame got=%h busy_end=%b", v[39:0], b[40]); end
`else
    wr_reg(2'd2, 32'h0003_0004, c);
    rd_reg(2'd2, r);
    checks++; if (r !== 32'h0000_0004) begin failures++; $display("FAIL div_upper_rd got=%h exp=00000004", r); end
    wr_reg(2'd0, 32'h03, c);
    s = c + 1;
    capture(s, 41, v, b);
    checks++; if (v[39:0] !== (frame_exp(8'h03, 4) & ones(40)) || v[40] !== 1'b1 || b[40] !== 1'b0) begin
      failures++; $display("FAIL plain_frame got=%h busy_end=%b", v[40:0], b[40]);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_frame;
    test_overflow;
    test_div_change;
    test_reset_mid;
    test_parity;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
